dma_rd_stream: RTL and testbench

DMA_RD_STREAM -- requirements
Module: dma_rd_stream

---
 rtl/dma_rd_stream.sv | 157 +++++++++++++++
 tb/tb_dma_rd_stream.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_stream.sv
// Streams a contiguous run of cache lines from memory into a show-ahead FIFO.
// Reads are issued only when the FIFO is guaranteed to have room for the response.
module dma_rd_stream #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 43,
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-7:0] mem_rd_addr,
    input  logic                  mem_rd_almost_full,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);
    localparam int LINE_WIDTH = ADDR_WIDTH - 6;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [LINE_WIDTH-1:0] req_ptr;
    logic [SIZE_WIDTH-1:0] req_remaining;
    logic [SIZE_WIDTH-1:0] pop_remaining;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                  go_accept;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CNT_WIDTH:0]    credit_used;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^rd_addr[5:0];

    assign go_accept   = rd_go && ((state == IDLE) || (state == DONE));
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    // Lines already buffered plus lines still in flight must leave a free slot.
    assign issue = (state == REQ) && (req_remaining != '0) && !mem_rd_almost_full
                   && (credit_used < (CNT_WIDTH + 1)'(FIFO_DEPTH));
    // With nothing in flight a response can only be stale, so it is dropped.
    assign push  = mem_rsp_valid && (outstanding != '0);
    assign pop   = rd_en && (fifo_count != '0);
    assign empty = (fifo_count == '0);
    assign rd_data = fifo_mem[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (rd_go) begin
                    state_next = (rd_size == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (req_remaining == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_remaining == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            req_ptr       <= '0;
            req_remaining <= '0;
            pop_remaining <= '0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            rd_done       <= 1'b0;
        end else begin
            state      <= state_next;
            mem_rd_req <= issue;

            if (go_accept) begin
                req_ptr       <= rd_addr[ADDR_WIDTH-1:6];
                req_remaining <= rd_size;
            end else if (issue) begin
                mem_rd_addr   <= req_ptr;
                req_ptr       <= req_ptr + LINE_WIDTH'(1);
                req_remaining <= req_remaining - SIZE_WIDTH'(1);
            end

            if (go_accept) begin
                pop_remaining <= rd_size;
            end else if (pop && (pop_remaining != '0)) begin
                pop_remaining <= pop_remaining - SIZE_WIDTH'(1);
            end

            if (go_accept) begin
                rd_done <= 1'b0;
            end else if (state == DONE) begin
                rd_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_count  <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end

            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_WIDTH'(1);
            end

            if (issue && !push) begin
                outstanding <= outstanding + CNT_WIDTH'(1);
            end else if (push && !issue) begin
                outstanding <= outstanding - CNT_WIDTH'(1);
            end
        end
    end

    // Line storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_dma_rd_stream.sv
// Randomized bench for dma_rd_stream: an in-order memory model with variable latency
// feeds the DUT, and a line-sequence scoreboard checks addresses, data and flags.
module tb_dma_rd_stream;
    localparam int ADDR_WIDTH = 64;
    localparam int SIZE_WIDTH = 43;
    localparam int DATA_WIDTH = 512;
    localparam int FIFO_DEPTH = 4;
    localparam int LINE_WIDTH = ADDR_WIDTH - 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rd_go = 1'b0;
    logic [ADDR_WIDTH-1:0] rd_addr = '0;
    logic [SIZE_WIDTH-1:0] rd_size = '0;
    logic                  rd_en = 1'b0;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  rd_done;
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-7:0] mem_rd_addr;
    logic                  mem_rd_almost_full = 1'b0;
    logic                  mem_rsp_valid = 1'b0;
    logic [DATA_WIDTH-1:0] mem_rsp_data = '0;

    dma_rd_stream #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .SIZE_WIDTH(SIZE_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_go             (rd_go),
        .rd_addr           (rd_addr),
        .rd_size           (rd_size),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .empty             (empty),
        .rd_done           (rd_done),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_almost_full(mem_rd_almost_full),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_data      (mem_rsp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Scoreboard: the transfer is just the line sequence exp_base, exp_base+1, ...
    logic [LINE_WIDTH-1:0] exp_base = '0;
    int exp_size = 0;
    int req_idx = 0;
    int pop_idx = 0;
    int model_count = 0;
    bit xfer_active = 1'b0;
    bit last_push = 1'b0;
    bit last_pop = 1'b0;

    int pop_mode = 1;
    int lat_min = 2;
    int lat_max = 2;
    int af_mode = 0;
    int af_trigger = 0;
    int af_left = 0;
    bit af_done = 1'b0;
    bit go_pulse = 1'b0;
    int last_due = 0;

    logic [LINE_WIDTH-1:0] pend_line[$];
    int                    pend_due[$];
    bit                    pend_stale[$];

    function automatic logic [DATA_WIDTH-1:0] line_data(input logic [LINE_WIDTH-1:0] line);
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < DATA_WIDTH / 64; i++) begin
            d[i*64 +: 64] = {line, 6'(i)} ^ (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] observed,
                               input logic [DATA_WIDTH-1:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: check what the last edge produced, then drive the next edge.
    task automatic applyStimulus();
        logic [LINE_WIDTH-1:0] line;
        logic [LINE_WIDTH-1:0] tmp_line;
        int lat;
        int due;
        int tmp_due;
        bit tmp_stale;
        @(negedge clk);
        cyc++;
        model_count += int'(last_push) - int'(last_pop);
        checkOutput("empty", DATA_WIDTH'(empty), DATA_WIDTH'(model_count == 0));
        if (xfer_active && (pop_idx < exp_size))
            checkOutput("rd_done_early", DATA_WIDTH'(rd_done), '0);
        if (mem_rd_almost_full)
            checkOutput("req_under_af", DATA_WIDTH'(mem_rd_req), '0);
        if (!xfer_active) begin
            checkOutput("req_idle", DATA_WIDTH'(mem_rd_req), '0);
        end else if (mem_rd_req) begin
            line = exp_base + LINE_WIDTH'(req_idx);
            checkOutput("mem_rd_addr", DATA_WIDTH'(mem_rd_addr), DATA_WIDTH'(line));
            checkOutput("req_within_size", DATA_WIDTH'(req_idx < exp_size), DATA_WIDTH'(1'b1));
            checkOutput("credit", DATA_WIDTH'((req_idx - pop_idx) < FIFO_DEPTH), DATA_WIDTH'(1'b1));
            req_idx++;
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            pend_line.push_back(line);
            pend_due.push_back(due);
            pend_stale.push_back(1'b0);
        end

        last_push = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = {(DATA_WIDTH / 32){32'hDEAD_BEEF}};
        if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
            tmp_line = pend_line.pop_front();
            tmp_due = pend_due.pop_front();
            tmp_stale = pend_stale.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data = line_data(tmp_line);
            last_push = !tmp_stale;
        end

        if (af_mode == 1) begin
            if (!af_done && (req_idx >= af_trigger)) begin
                af_left = 5;
                af_done = 1'b1;
            end
            mem_rd_almost_full = (af_left > 0);
            if (af_left > 0) af_left--;
        end else if (af_mode == 2) begin
            mem_rd_almost_full = ($urandom_range(3, 0) == 0);
        end else begin
            mem_rd_almost_full = 1'b0;
        end

        rd_go = 1'b0;
        if (go_pulse && xfer_active && (req_idx >= 1) && (pop_idx < exp_size)) begin
            rd_go = 1'b1;
            rd_addr = {$urandom, $urandom};
            rd_size = SIZE_WIDTH'($urandom_range(7, 1));
        end

        last_pop = 1'b0;
        case (pop_mode)
            0: rd_en = 1'b0;
            1: rd_en = !empty;
            default: rd_en = ($urandom_range(1, 0) == 1);
        endcase
        if (rd_en && (model_count > 0)) begin
            checkOutput("rd_data", rd_data, line_data(exp_base + LINE_WIDTH'(pop_idx)));
            pop_idx++;
            last_pop = 1'b1;
        end
    endtask

    task automatic start_transfer(input logic [LINE_WIDTH-1:0] line, input int size);
        exp_base = line;
        exp_size = size;
        req_idx = 0;
        pop_idx = 0;
        xfer_active = 1'b1;
        af_done = 1'b0;
        af_left = 0;
        rd_addr = {line, 6'b0};
        rd_size = SIZE_WIDTH'(size);
        rd_go = 1'b1;
        applyStimulus();
    endtask

    task automatic finish_transfer(input string tag, input int budget);
        int n;
        n = 0;
        while ((pop_idx < exp_size) && (n < budget)) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_lines"}, DATA_WIDTH'(pop_idx), DATA_WIDTH'(exp_size));
        n = 0;
        while ((rd_done !== 1'b1) && (n < 6)) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_rd_done"}, DATA_WIDTH'(rd_done), DATA_WIDTH'(1'b1));
        checkOutput({tag, "_reqs"}, DATA_WIDTH'(req_idx), DATA_WIDTH'(exp_size));
    endtask

    initial begin
        logic [LINE_WIDTH-1:0] wrap_base;
        logic [LINE_WIDTH-1:0] rand_base;
        int n;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_empty", DATA_WIDTH'(empty), DATA_WIDTH'(1'b1));
        checkOutput("reset_req", DATA_WIDTH'(mem_rd_req), '0);
        checkOutput("reset_addr", DATA_WIDTH'(mem_rd_addr), '0);
        checkOutput("reset_done", DATA_WIDTH'(rd_done), '0);
        rst = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] basic transfer");
        start_transfer(LINE_WIDTH'(64'h40), 4);
        finish_transfer("basic", 40);

        $display("[TB] zero size");
        start_transfer(LINE_WIDTH'(64'h123), 0);
        checkOutput("zero_done_c1", DATA_WIDTH'(rd_done), '0);
        applyStimulus();
        checkOutput("zero_done_c2", DATA_WIDTH'(rd_done), DATA_WIDTH'(1'b1));
        repeat (4) applyStimulus();
        checkOutput("zero_reqs", DATA_WIDTH'(req_idx), '0);

        $display("[TB] credit stall");
        pop_mode = 0;
        start_transfer(LINE_WIDTH'(64'h2000), 10);
        repeat (25) applyStimulus();
        checkOutput("stall_reqs", DATA_WIDTH'(req_idx), DATA_WIDTH'(FIFO_DEPTH));
        checkOutput("stall_empty", DATA_WIDTH'(empty), '0);
        pop_mode = 1;
        finish_transfer("stall", 100);

        $display("[TB] back-pressure");
        af_mode = 1;
        af_trigger = 3;
        start_transfer(LINE_WIDTH'(64'h3_0000), 12);
        finish_transfer("bp", 100);
        af_mode = 0;

        $display("[TB] address wrap with ignored go");
        wrap_base = '1;
        wrap_base = wrap_base - LINE_WIDTH'(1);
        go_pulse = 1'b1;
        start_transfer(wrap_base, 3);
        finish_transfer("wrap", 40);
        go_pulse = 1'b0;

        $display("[TB] randomized transfers");
        pop_mode = 2;
        af_mode = 2;
        lat_min = 1;
        lat_max = 5;
        for (int t = 0; t < 6; t++) begin
            rand_base = LINE_WIDTH'({$urandom, $urandom});
            if (t == 0) rand_base = '1;
            start_transfer(rand_base, int'($urandom_range(20, 1)));
            finish_transfer("rand", 400);
        end
        pop_mode = 1;
        af_mode = 0;
        lat_min = 2;
        lat_max = 2;

        $display("[TB] reset mid-transfer");
        start_transfer(LINE_WIDTH'(64'h5000), 8);
        n = 0;
        while ((pop_idx < 2) && (n < 50)) begin
            applyStimulus();
            n++;
        end
        checkOutput("mid_pops", DATA_WIDTH'(pop_idx), DATA_WIDTH'(2));
        rst = 1'b0;
        rd_en = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("mid_reset_empty", DATA_WIDTH'(empty), DATA_WIDTH'(1'b1));
        checkOutput("mid_reset_req", DATA_WIDTH'(mem_rd_req), '0);
        checkOutput("mid_reset_done", DATA_WIDTH'(rd_done), '0);
        model_count = 0;
        last_push = 1'b0;
        last_pop = 1'b0;
        xfer_active = 1'b0;
        for (int i = 0; i < pend_stale.size(); i++) pend_stale[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pop_mode = 2;
        repeat (10) applyStimulus();
        pop_mode = 1;
        start_transfer(LINE_WIDTH'(64'h6000), 2);
        finish_transfer("after_reset", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
